// File: rtl/alu_flag_sequencer.sv
// Single-op ALU sequencer: condition check against NZCV, fixed-latency launch, writeback and flag commit.
// Optional WB-cycle accept with flag forwarding under `ALU_FLAG_SEQ_FWD_EN.
module alu_flag_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_cond,
  input  logic       op_s,
  output logic       alu_go,
  output logic       alu_cin,
  input  logic [3:0] alu_new_flag,
  input  logic       flag_wr_en,
  input  logic [3:0] flag_wr_data,
  output logic       wb_valid,
  output logic       wb_en,
  output logic [3:0] flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] LAT4 = 4'(ALU_LAT);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       s_lat;
  logic [3:0] eval_flags;
  logic       cond_ok;
  logic       accept;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = !z;
      4'd2:    cond_pass = cf;
      4'd3:    cond_pass = !cf;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = !n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = !v;
      4'd8:    cond_pass = cf & !z;
      4'd9:    cond_pass = !cf | z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = !z & (n == v);
      4'd13:   cond_pass = z | (n != v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

`ifdef ALU_FLAG_SEQ_FWD_EN
  // An op accepted in WB must see the flags the completing op is about to commit.
  assign eval_flags = (state == S_WB && s_lat) ? alu_new_flag : flags;
  assign op_ready   = (state == S_IDLE || state == S_WB) && !flag_wr_en;
`else
  assign eval_flags = flags;
  assign op_ready   = (state == S_IDLE) && !flag_wr_en;
`endif

  assign accept   = op_valid & op_ready;
  assign cond_ok  = cond_pass(op_cond, eval_flags);
  assign alu_go   = (state == S_EXEC) && (cnt == LAT4);
  assign wb_valid = (state == S_SKIP) || (state == S_WB);
  assign wb_en    = (state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      s_lat   <= 1'b0;
      alu_cin <= 1'b0;
      flags   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: if (flag_wr_en) flags <= flag_wr_data;
        S_SKIP: state <= S_IDLE;
        S_EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_WB;
        end
        default: begin
          if (s_lat) flags <= alu_new_flag;
          state <= S_IDLE;
        end
      endcase
      // Accept overrides the state update above; only reachable from IDLE (or WB when forwarding).
      if (accept) begin
        s_lat   <= op_s;
        alu_cin <= eval_flags[1];
        if (cond_ok) begin
          state <= S_EXEC;
          cnt   <= LAT4;
        end else begin
          state <= S_SKIP;
        end
      end
    end
  end

endmodule

// File: doc/alu_flag_sequencer.md
Name: alu_flag_sequencer

Overview:
- Sequences one ALU operation at a time: accepts an op, evaluates its 4-bit condition code against the architectural NZCV flag register, and launches the ALU only when the condition passes.
- Waits a fixed ALU latency, then signals writeback and commits New_Flag from the set-flag logic when the op's S bit is set.
- Sits between decode/issue and the ALU + flag-setting datapath, and owns the NZCV register.

Parameters:
- ALU_LAT, 1, cycles from alu_go to a valid ALU result / new-flag vector; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  issue request
- op_ready  out  1  sequencer can accept; op transfers when op_valid & op_ready
- op_cond  in  4  condition code (encoding below)
- op_s  in  1  update flags on completion
- alu_go  out  1  one-cycle launch pulse to ALU
- alu_cin  out  1  carry-in to ALU = C flag captured at accept, held stable while busy
- alu_new_flag  in  4  {N,Z,C,V} from set-flag logic; sampled in the WB cycle
- flag_wr_en  in  1  direct flag write (MSR-type)
- flag_wr_data  in  4  {N,Z,C,V} for direct write
- wb_valid  out  1  one-cycle completion pulse per accepted op
- wb_en  out  1  qualifies wb_valid: 1 = condition passed, write result; 0 = skipped
- flags  out  4  registered NZCV: [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Reset (async, rst_n=0): state=IDLE, flags=4'b0000, alu_go=0, wb_valid=0, wb_en=0, alu_cin=0, counter=0.
- Reset is effective mid-operation: any in-flight op is abandoned with no wb_valid. op_ready=1 on the first cycle after release.
- Condition encoding, evaluated on the current flags register:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL always passes; 15 NV never passes.
- States:
  - IDLE: op_ready = !flag_wr_en.
    - On accept, latch op_s and alu_cin=C.
    - Condition fails -> SKIP. Condition passes -> EXEC, with counter loaded to ALU_LAT.
  - SKIP: wb_valid=1, wb_en=0, flags unchanged; -> IDLE.
  - EXEC: alu_go=1 in the first EXEC cycle only. Counter decrements each cycle; at 1 -> WB. Total EXEC cycles = ALU_LAT.
  - WB: wb_valid=1, wb_en=1. If latched op_s, flags <= alu_new_flag at the clock edge ending WB; else flags unchanged. -> IDLE.
- Latency from accept edge T:
  - Pass: alu_go visible in cycle T+1; wb_valid in cycle T+1+ALU_LAT; new flags visible from T+2+ALU_LAT.
  - Fail: wb_valid in cycle T+1.
- Throughput without the optional feature: one op per ALU_LAT+2 cycles (pass) or per 2 cycles (fail).
- flag_wr_en:
  - Honoured only in IDLE: flags <= flag_wr_data, and op_ready is forced 0 that cycle, so a direct write and an accept never coincide.
  - Ignored in SKIP/EXEC/WB; issue logic must hold the write until op_ready would be 1.
- op_cond/op_s are don't-care when no transfer occurs. Inputs other than alu_new_flag are not sampled while busy.

Optional Feature:
- Macro: ALU_FLAG_SEQ_FWD_EN.
- Defined:
  - op_ready is also asserted in WB (still gated by !flag_wr_en, which remains ignored in WB).
  - An op accepted in WB evaluates its condition on the forwarded flags: alu_new_flag if the completing op's S=1, else the current flags. alu_cin takes C from the same forwarded value.
  - Transition is WB -> SKIP or WB -> EXEC directly, giving back-to-back throughput of one op per ALU_LAT+1 cycles.
- Undefined: op_ready only in IDLE, exactly as above.

Test Plan:
1. Reset, then flags=0, op_cond=0 (EQ), op_s=1 -> SKIP. wb_valid=1, wb_en=0 in cycle T+1, no alu_go, flags stay 0000.
2. ALU_LAT=1, op_cond=14, op_s=1, alu_new_flag=4'b0100 -> alu_go at T+1, wb_valid=1/wb_en=1 at T+2, flags=0100 at T+3. Repeat with op_s=0 -> flags unchanged.
3. flag_wr_en=1, flag_wr_data=4'b0011 with op_valid=1 in IDLE -> op_ready=0 that cycle, flags=0011. Next op with cond 2 (CS) passes and alu_cin=1. Cond 8 (HI) with flags 0011 passes; with 0111 fails.
4. ALU_LAT=3, assert rst_n=0 during the second EXEC cycle -> outputs zero immediately, no wb_valid. After release op_ready=1, flags=0000.
5. Sweep all 16 op_cond against all 16 flag values via direct writes -> wb_en matches the encoding table. Cond 15 always gives wb_en=0.
6. With ALU_FLAG_SEQ_FWD_EN, ALU_LAT=1: op A (AL, S=1, alu_new_flag=0100) followed immediately by op B (EQ) held valid -> B accepted in A's WB cycle and passes via forwarded Z. B's alu_go occurs one cycle after A's wb_valid. Without the macro, B is accepted one cycle later.
